// File: rtl/seg_display_scan.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS hex digits over a shared
// active-low cathode bus, with per-slot blanking, per-digit enable/blink and shadow loading.
module seg_display_scan #(
   parameter int NUM_DIGITS   = 2,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 64,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digit_values,
   input  logic [NUM_DIGITS-1:0]   digit_enable,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              cathode,
   output logic [IDX_W-1:0]        scan_index,
   output logic                    frame_tick
);

   localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LIM = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_DIV - 1);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLANK_CYCLES < 0 ||
       BLANK_CYCLES >= REFRESH_DIV || BLINK_DIV < 1) begin : g_param_check
      $error("seg_display_scan: illegal parameter combination");
   end

   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [FRM_W-1:0]        frame_q, frame_d;
   logic                    blink_q, blink_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d;
   logic [NUM_DIGITS-1:0]   en_q, en_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              cathode_q, cathode_d;
   logic                    tick_q, tick_d;
   logic                    slot_wrap, frame_wrap, lit;
   logic [3:0]              sel_nib;
   logic                    sel_en, sel_mask;
   logic [3:0]              nib [NUM_DIGITS];

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h7F;
      case (n)
         4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;  4'hF: s = 7'b0111000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = val_d[4*gi +: 4];
   end

   always_comb begin
      slot_wrap  = (slot_q == SLOT_LAST);
      frame_wrap = slot_wrap && (idx_q == IDX_LAST);
      slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
      idx_d      = idx_q;
      frame_d    = frame_q;
      blink_d    = blink_q;
      if (frame_wrap) begin
         idx_d = '0;
         if (frame_q == FRM_LAST) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end else if (slot_wrap) begin
         idx_d = idx_q + 1'b1;
      end
      tick_d = frame_wrap;
      // A load on a wrap edge is visible in the very slot it opens.
      val_d  = load ? digit_values : val_q;
      en_d   = load ? digit_enable : en_q;
      mask_d = load ? blink_mask   : mask_q;
   end

   // Outputs are derived from next-state so they update on the same edge as the state.
   always_comb begin
      sel_nib  = 4'h0;
      sel_en   = 1'b0;
      sel_mask = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            sel_nib  = nib[k];
            sel_en   = en_d[k];
            sel_mask = mask_d[k];
         end
      end
      lit       = (slot_d >= BLANK_LIM) && sel_en && !(sel_mask && blink_d);
      anode_d   = '1;
      cathode_d = 7'h7F;
      if (lit) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_d[k] = (idx_d != IDX_W'(k));
         end
         cathode_d = seg_decode(sel_nib);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_q    <= '0;
         idx_q     <= '0;
         frame_q   <= '0;
         blink_q   <= 1'b0;
         val_q     <= '0;
         en_q      <= '0;
         mask_q    <= '0;
         anode_q   <= '1;
         cathode_q <= 7'h7F;
         tick_q    <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         idx_q     <= idx_d;
         frame_q   <= frame_d;
         blink_q   <= blink_d;
         val_q     <= val_d;
         en_q      <= en_d;
         mask_q    <= mask_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
         tick_q    <= tick_d;
      end
   end

   assign anode      = anode_q;
   assign cathode    = cathode_q;
   assign scan_index = idx_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: a 2-digit and a 1-digit instance checked every cycle
// against a closed-form timing model, plus directed literal expectations.
module tb_seg_display_scan;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;

   logic       load2 = 1'b0;
   logic [7:0] val2 = '0;
   logic [1:0] en2 = '0, mask2 = '0;
   logic [1:0] anode2;
   logic [6:0] cath2;
   logic [0:0] idx2;
   logic       tick2;

   logic       load1 = 1'b0;
   logic [3:0] val1 = '0;
   logic [0:0] en1 = '0, mask1 = '0;
   logic [0:0] anode1;
   logic [6:0] cath1;
   logic [0:0] idx1;
   logic       tick1;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] SEG_TAB [0:15] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   always #5 clock = ~clock;

   seg_display_scan #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .load(load2), .digit_values(val2),
      .digit_enable(en2), .blink_mask(mask2), .anode(anode2), .cathode(cath2),
      .scan_index(idx2), .frame_tick(tick2));

   seg_display_scan #(.NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(2)) dut1 (
      .clock(clock), .reset_n(reset_n), .load(load1), .digit_values(val1),
      .digit_enable(en1), .blink_mask(mask1), .anode(anode1), .cathode(cath1),
      .scan_index(idx1), .frame_tick(tick1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Edges since reset release and the shadow contents a correct display must hold.
   int         k2, k1;
   logic [7:0] sv2;
   logic [1:0] se2, sm2;
   logic [3:0] sv1;
   logic [0:0] se1, sm1;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         k2 <= 0; sv2 <= '0; se2 <= '0; sm2 <= '0;
         k1 <= 0; sv1 <= '0; se1 <= '0; sm1 <= '0;
      end else begin
         k2 <= k2 + 1;
         k1 <= k1 + 1;
         if (load2) begin sv2 <= val2; se2 <= en2; sm2 <= mask2; end
         if (load1) begin sv1 <= val1; se1 <= en1; sm1 <= mask1; end
      end
   end

   function automatic void model(input int k, input int n, input int r, input int bl,
                                 input int b, input logic [31:0] vals,
                                 input logic [7:0] en, input logic [7:0] mask,
                                 output logic [7:0] an, output logic [6:0] ca,
                                 output int idx, output logic tick);
      int  slot;
      int  frames;
      logic phase;
      slot   = k % r;
      idx    = (k / r) % n;
      tick   = (k > 0) && (slot == 0) && (idx == 0);
      frames = k / (r * n);
      phase  = ((frames / b) % 2) == 1;
      an = 8'hFF;
      ca = 7'h7F;
      if (slot >= bl && en[idx] && !(mask[idx] && phase)) begin
         an[idx] = 1'b0;
         ca = SEG_TAB[vals[4*idx +: 4]];
      end
   endfunction

   logic [7:0] m_an;
   logic [6:0] m_ca;
   int         m_idx;
   logic       m_tick;

   always @(negedge clock) begin
      model(k2, 2, 4, 1, 2, {24'b0, sv2}, {6'b0, se2}, {6'b0, sm2}, m_an, m_ca, m_idx, m_tick);
      check("model2.anode", 32'(anode2), 32'(m_an[1:0]));
      check("model2.cathode", 32'(cath2), 32'(m_ca));
      check("model2.scan_index", 32'(idx2), 32'(m_idx));
      check("model2.frame_tick", 32'(tick2), 32'(m_tick));
      model(k1, 1, 4, 1, 2, {28'b0, sv1}, {7'b0, se1}, {7'b0, sm1}, m_an, m_ca, m_idx, m_tick);
      check("model1.anode", 32'(anode1), 32'(m_an[0]));
      check("model1.cathode", 32'(cath1), 32'(m_ca));
      check("model1.scan_index", 32'(idx1), 32'(m_idx));
      check("model1.frame_tick", 32'(tick1), 32'(m_tick));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int lit0, lit1;
      logic [0:0] prev_idx;

      // Reset and idle
      cyc(3);
      check("reset.anode2", 32'(anode2), 32'h3);
      check("reset.cathode2", 32'(cath2), 32'h7F);
      check("reset.scan_index2", 32'(idx2), 32'h0);
      check("reset.frame_tick2", 32'(tick2), 32'h0);
      check("reset.anode1", 32'(anode1), 32'h1);
      reset_n = 1'b1;
      cyc(1);
      check("release.frame_tick2", 32'(tick2), 32'h0);
      cyc(12);
      check("idle.anode2", 32'(anode2), 32'h3);

      // Scan order with 8'h21
      val2 = 8'h21; en2 = 2'b11; mask2 = 2'b00; load2 = 1'b1;
      cyc(1);
      load2 = 1'b0;
      t = 0;
      while (anode2 != 2'b10 && t < 20) begin cyc(1); t++; end
      check("scan.digit0_anode", 32'(anode2), 32'h2);
      check("scan.digit0_cathode", 32'(cath2), 32'(7'b1001111));
      t = 0;
      while (anode2 != 2'b01 && t < 20) begin cyc(1); t++; end
      check("scan.digit1_anode", 32'(anode2), 32'h1);
      check("scan.digit1_cathode", 32'(cath2), 32'(7'b0010010));
      t = 0;
      while (!tick2 && t < 20) begin cyc(1); t++; end
      check("scan.tick_seen", 32'(tick2), 32'h1);
      check("scan.tick_index", 32'(idx2), 32'h0);
      t = 0;
      prev_idx = idx2;
      do begin prev_idx = idx2; cyc(1); t++; end while (!tick2 && t < 20);
      check("scan.tick_period", 32'(t), 32'd8);
      check("scan.tick_prev_index", 32'(prev_idx), 32'h1);

      // Enable and blink: digit 1 dark, digit 0 lit 2 frames of every 4
      en2 = 2'b01; mask2 = 2'b01; load2 = 1'b1;
      cyc(1);
      load2 = 1'b0;
      t = 0;
      while (!tick2 && t < 20) begin cyc(1); t++; end
      check("blink.tick_seen", 32'(tick2), 32'h1);
      lit0 = 0; lit1 = 0;
      for (int i = 0; i < 64; i++) begin
         if (anode2[0] == 1'b0) lit0++;
         if (anode2[1] == 1'b0) lit1++;
         cyc(1);
      end
      check("blink.digit0_lit_cycles", 32'(lit0), 32'd12);
      check("blink.digit1_lit_cycles", 32'(lit1), 32'd0);

      // Load coinciding with the wrap into digit 0
      val2 = 8'h21; en2 = 2'b11; mask2 = 2'b00; load2 = 1'b1;
      cyc(1);
      load2 = 1'b0;
      t = 0;
      while (!tick2 && t < 20) begin cyc(1); t++; end
      check("boundary.tick_seen", 32'(tick2), 32'h1);
      cyc(7);
      val2 = 8'hEF; load2 = 1'b1;
      cyc(1);
      load2 = 1'b0;
      check("boundary.tick", 32'(tick2), 32'h1);
      check("boundary.blank_anode", 32'(anode2), 32'h3);
      cyc(1);
      check("boundary.anode", 32'(anode2), 32'h2);
      check("boundary.cathode_F", 32'(cath2), 32'(7'b0111000));

      // Decode sweep on the single-digit instance
      for (int v = 0; v < 16; v++) begin
         val1 = 4'(v); en1 = 1'b1; mask1 = 1'b0; load1 = 1'b1;
         cyc(1);
         load1 = 1'b0;
         t = 0;
         while (anode1 != 1'b0 && t < 10) begin cyc(1); t++; end
         check($sformatf("decode.%0h", v), 32'(cath1), 32'(SEG_TAB[v]));
      end
      t = 0;
      while (!tick1 && t < 10) begin cyc(1); t++; end
      check("single.tick_seen", 32'(tick1), 32'h1);
      t = 0;
      do begin cyc(1); t++; end while (!tick1 && t < 10);
      check("single.tick_period", 32'(t), 32'd4);

      // Asynchronous reset in the middle of a lit slot
      t = 0;
      while (anode2 != 2'b10 && t < 20) begin cyc(1); t++; end
      check("areset.pre_anode", 32'(anode2), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check("areset.anode2", 32'(anode2), 32'h3);
      check("areset.cathode2", 32'(cath2), 32'h7F);
      check("areset.scan_index2", 32'(idx2), 32'h0);
      check("areset.anode1", 32'(anode1), 32'h1);
      cyc(2);
      reset_n = 1'b1;
      lit0 = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (anode2 != 2'b11 || cath2 != 7'h7F) lit0++;
      end
      check("areset.dark_after_release", 32'(lit0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised, time-multiplexed seven-segment driver for N hex digits sharing one active-low cathode bus.
- Scans one digit per refresh slot and adds anti-ghost blanking, per-digit enable and blink, and a load strobe that latches new values into shadow registers.
- Sits between the memory-block select/status logic and the board display pins. Standalone; no controller handshake beyond the load strobe.

Parameters:
- NUM_DIGITS, 2, number of digits/anodes; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_DIV, 64, completed frames per blink half-period; must be >= 1.

Ports:
- clock, in, 1, system clock; all state changes on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- load, in, 1, single-cycle strobe that latches digit_values, digit_enable and blink_mask.
- digit_values, in, 4*NUM_DIGITS, hex nibble per digit; digit k at bits [4k+3:4k]. Digit 0 is the rightmost.
- digit_enable, in, NUM_DIGITS, 1 = digit lit; 0 = digit permanently blank.
- blink_mask, in, NUM_DIGITS, 1 = digit blanks during blink phase 1.
- anode, out, NUM_DIGITS, active-low digit selects; bit k drives digit k.
- cathode, out, 7, active-low segments; cathode[6]=a … cathode[0]=g.
- scan_index, out, $clog2(NUM_DIGITS) (min 1), digit currently being scanned.
- frame_tick, out, 1, one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - anode = all 1s; cathode = 7'b111_1111; scan_index = 0; frame_tick = 0.
  - Slot counter = 0; frame counter = 0; blink_phase = 0.
  - Shadow digit_values = 0, digit_enable = 0, blink_mask = 0.
  - Reset mid-scan forces these values immediately, whatever the state.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0 on the cycle after REFRESH_DIV-1.
  - On wrap, scan_index increments; scan_index = NUM_DIGITS-1 wraps to 0.
  - NUM_DIGITS = 1: scan_index stays 0 and every wrap is a frame wrap.
- frame_tick: high for exactly the one cycle in which scan_index becomes 0 through wrap. Never asserted on reset release.
- Blink:
  - The frame counter counts frame_tick pulses 0..BLINK_DIV-1.
  - On the pulse where it wraps, blink_phase toggles.
- Shadow registers:
  - On load = 1, all three shadow registers capture the inputs at that edge.
  - Inputs are ignored while load = 0.
  - A load coinciding with a slot wrap is captured, and the new slot already displays the new values.
- Registered outputs: anode, cathode, scan_index and frame_tick are flops. They are computed from next-state (slot counter, scan_index, shadow, blink_phase) so all outputs change on the same edge as the internal state. There is no added latency.
- Per-cycle output rule:
  - If next slot count < BLANK_CYCLES, then anode = all 1s and cathode = all 1s.
  - Else if shadow digit_enable[i] = 0, or (blink_mask[i] = 1 and blink_phase = 1), then anode = all 1s and cathode = all 1s.
  - Otherwise anode = all 1s except bit i = 0, and cathode = decode(nibble i).
  - Here i is the next scan_index.
- Exactly zero or one anode bit is low in any cycle.
- Decode (abcdefg, 0 = lit):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Synthesis:
  - Parameters outside the legal ranges must be flagged by an elaboration-time assertion.
  - No latches.
  - No logic on the negedge of clock.

Test Plan:
- Reset/idle (NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1): hold reset_n=0 for 3 cycles, then release -> anode=2'b11, cathode=7'h7F, scan_index=0, frame_tick=0. No load issued, so anode stays 2'b11 permanently.
- Scan order: load digit_values=8'h21, digit_enable=2'b11, blink_mask=0 -> per slot, 1 blank cycle then 3 cycles of that slot's digit:
  - slot for digit 0: anode=2'b10, cathode=1001111;
  - slot for digit 1: anode=2'b01, cathode=0010010.
  - frame_tick pulses every 8 cycles, aligned with scan_index 1->0.
- Full decode sweep (NUM_DIGITS=1): load each nibble 0..F in turn -> cathode matches the table for every value. frame_tick fires every REFRESH_DIV cycles.
- Enable/blink (BLINK_DIV=2): digit_enable=2'b01, blink_mask=2'b01 -> digit 1 is never lit. Digit 0 is lit for 2 frames, then dark for 2 frames, repeating.
- Load at slot boundary: assert load with value 8'hEF on the same edge as the slot wrap into digit 0 -> the first lit cycle of that slot shows F (0111000), not the old value.
- Async reset mid-slot: drop reset_n between clock edges while anode=2'b10 -> anode=2'b11 and cathode=7'h7F without waiting for an edge. After release, shadow values are 0 and the display stays dark.
